// File: rtl/alu_nibble_seq.sv
// Multi-nibble sequencer around a 4-bit ALU.
// Feeds operand nibbles LSB first, chains carry, assembles result and whole-word flags.
module alu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic [2:0]           op,
    input  logic                 cin,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic                 alu_cin,
    output logic [2:0]           alu_op,
    input  logic [3:0]           alu_r,
    input  logic                 alu_zero,
    input  logic                 alu_carry,
    input  logic                 alu_sign,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 zero,
    output logic                 carry,
    output logic                 sign
);

    localparam int WIDTH = 4 * NIBBLES;
    localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]     op_q;
    logic           cin_q;
    logic           chain_q;
    logic           zero_acc;
    logic [WIDTH-1:0] result_q;
    logic           zero_q;
    logic           carry_q;
    logic           sign_q;
    logic           accept;
    logic           last;

    // Start is honoured only when no operation is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (idx == IW'(NIBBLES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE is a single-cycle state.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on an accepted start; inputs are free afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cin_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cin_q <= cin;
        end
    end

    // Nibble index and inter-nibble carry chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            chain_q <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
        end else if (state == RUN) begin
            idx     <= last ? '0 : idx + IW'(1);
            chain_q <= alu_carry;
        end
    end

    // Result assembly and running zero accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_acc <= 1'b0;
        end else if (accept) begin
            result_q <= '0;
            zero_acc <= 1'b1;
        end else if (state == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == IW'(i)) result_q[4*i +: 4] <= alu_r;
            end
            zero_acc <= zero_acc & alu_zero;
        end
    end

    // Whole-word flags change only when the final nibble is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            sign_q  <= 1'b0;
        end else if (last) begin
            zero_q  <= zero_acc & alu_zero;
            carry_q <= alu_carry;
            sign_q  <= alu_sign;
        end
    end

    // ALU drive comes from registered state only.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                alu_a = a_q[4*i +: 4];
                alu_b = b_q[4*i +: 4];
            end
        end
        alu_cin = (idx == '0) ? cin_q : chain_q;
        alu_op  = op_q;
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign result = result_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign sign   = sign_q;

endmodule
